// File: rtl/sensor_hub_pkg.sv
// sensor_hub shared definitions.
// Host command set, response codes and controller states.
package sensor_hub_pkg;

    localparam logic [7:0] CMD_STATUS    = 8'h00;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_HUM       = 8'h02;
    localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
    localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
    localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
    localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

    localparam logic [7:0] RSP_STATUS_OK = 8'h07;
    localparam logic [7:0] RSP_HUM       = 8'h08;
    localparam logic [7:0] RSP_TEMP      = 8'h09;
    localparam logic [7:0] RSP_STOP_TEMP = 8'h0A;
    localparam logic [7:0] RSP_STOP_HUM  = 8'h0B;
    localparam logic [7:0] RSP_CONT_TEMP = 8'h0D;
    localparam logic [7:0] RSP_CONT_HUM  = 8'h0E;
    localparam logic [7:0] RSP_ERROR     = 8'h1F;
    localparam logic [7:0] RSP_BAD_CMD   = 8'hFE;
    localparam logic [7:0] RSP_BAD_ADDR  = 8'hFF;

    localparam logic [7:0] MEAS_STATUS = 8'h00;
    localparam logic [7:0] MEAS_TEMP   = 8'h01;
    localparam logic [7:0] MEAS_HUM    = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_DISPATCH,
        S_WAIT_SENSOR,
        S_SEND_CODE,
        S_SEND_DATA
    } state_t;

    // Measurement type driven to the sensor for a read command.
    function automatic logic [7:0] meas_type(input logic [7:0] cmd);
        case (cmd)
            CMD_TEMP, CMD_CONT_TEMP: return MEAS_TEMP;
            CMD_HUM, CMD_CONT_HUM:   return MEAS_HUM;
            default:                 return MEAS_STATUS;
        endcase
    endfunction

    // Success response code for a completed read command.
    function automatic logic [7:0] rsp_code(input logic [7:0] cmd);
        case (cmd)
            CMD_TEMP:      return RSP_TEMP;
            CMD_HUM:       return RSP_HUM;
            CMD_CONT_TEMP: return RSP_CONT_TEMP;
            CMD_CONT_HUM:  return RSP_CONT_HUM;
            default:       return RSP_STATUS_OK;
        endcase
    endfunction

endpackage

// File: rtl/sensor_hub_timer.sv
// hub_timer: saturating up-counter with clear.
// expired is high while the count equals LIMIT.
module hub_timer #(
    parameter int unsigned LIMIT = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    assign expired = (count == W'(LIMIT));

    // Count up while enabled, hold at LIMIT, clear has priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sensor_hub.sv
// sensor_hub: host request controller for single-wire sensors.
// Assembles requests, dispatches reads, frames two-byte replies.
module sensor_hub
    import sensor_hub_pkg::*;
#(
    parameter int NUM_SENSORS        = 32,
    parameter int TIMEOUT_CYCLES     = 50_000_000,
    parameter int POLL_PERIOD_CYCLES = 100_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [NUM_SENSORS-1:0]   sensor_start,
    output logic [7:0]               sensor_command,
    input  logic [NUM_SENSORS-1:0]   sensor_done,
    input  logic [NUM_SENSORS-1:0]   sensor_error,
    input  logic [8*NUM_SENSORS-1:0] sensor_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     busy
);

    localparam int AW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam logic [NUM_SENSORS-1:0] ONE = NUM_SENSORS'(1);

    state_t          state;
    state_t          state_d;
    logic [7:0]      cmd_q;
    logic [AW-1:0]   addr_q;
    logic [7:0]      data_q;
    logic            cont_active;
    logic [7:0]      cont_cmd;
    logic [AW-1:0]   cont_addr;
    logic            poll_pending;

    logic            to_expired;
    logic            poll_expired;
    logic            poll_clear;
    logic            addr_bad;
    logic            cmd_bad;
    logic            cmd_stop;
    logic            cmd_cont;
    logic            cont_start;
    logic            poll_go;
    logic            sel_done;
    logic            sel_err;
    logic [7:0]      sel_data;

    assign addr_bad   = {24'd0, rx_data} >= NUM_SENSORS;
    assign cmd_bad    = cmd_q > CMD_STOP_HUM;
    assign cmd_stop   = (cmd_q == CMD_STOP_TEMP) || (cmd_q == CMD_STOP_HUM);
    assign cmd_cont   = (cmd_q == CMD_CONT_TEMP) || (cmd_q == CMD_CONT_HUM);
    assign cont_start = (state == S_WAIT_ADDR) && rx_valid && !addr_bad && cmd_cont;
    assign poll_go    = (state == S_IDLE) && !rx_valid && poll_pending;
    assign poll_clear = !cont_active || poll_go || cont_start;
    assign sel_done   = sensor_done[addr_q];
    assign sel_err    = sensor_error[addr_q];
    assign sel_data   = sensor_data[{addr_q, 3'b000} +: 8];

    hub_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   ((state == S_IDLE) || (state == S_DISPATCH)),
        .enable  ((state == S_WAIT_ADDR) || (state == S_WAIT_SENSOR)),
        .expired (to_expired)
    );

    hub_timer #(.LIMIT(POLL_PERIOD_CYCLES)) u_poll (
        .clock   (clock),
        .reset   (reset),
        .clear   (poll_clear),
        .enable  (cont_active),
        .expired (poll_expired)
    );

    // Next-state selection; host bytes take priority over a pending poll.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (rx_valid) state_d = S_WAIT_ADDR;
                else if (poll_pending) state_d = S_DISPATCH;
            end
            S_WAIT_ADDR: begin
                if (rx_valid) begin
                    if (addr_bad || cmd_bad || cmd_stop) state_d = S_SEND_CODE;
                    else state_d = S_DISPATCH;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH:    state_d = S_WAIT_SENSOR;
            S_WAIT_SENSOR: if (sel_done || to_expired) state_d = S_SEND_CODE;
            S_SEND_CODE:   if (tx_ready) state_d = S_SEND_DATA;
            S_SEND_DATA:   if (tx_ready) state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Request latching, continuous job bookkeeping and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            cmd_q          <= 8'h00;
            addr_q         <= '0;
            data_q         <= 8'h00;
            cont_active    <= 1'b0;
            cont_cmd       <= 8'h00;
            cont_addr      <= '0;
            poll_pending   <= 1'b0;
            sensor_start   <= '0;
            sensor_command <= MEAS_STATUS;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
        end else begin
            state        <= state_d;
            busy         <= (state_d != S_IDLE);
            sensor_start <= '0;
            if (cont_active && poll_expired) poll_pending <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        cmd_q <= rx_data;
                    end else if (poll_pending) begin
                        cmd_q        <= cont_cmd;
                        addr_q       <= cont_addr;
                        poll_pending <= 1'b0;
                    end
                end
                S_WAIT_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= rx_data[AW-1:0];
                        data_q <= 8'h00;
                        if (cmd_stop || cont_start) begin
                            cont_active  <= cont_start;
                            cont_cmd     <= cmd_q;
                            cont_addr    <= rx_data[AW-1:0];
                            poll_pending <= 1'b0;
                        end
                        if (addr_bad) begin
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_BAD_ADDR;
                        end else if (cmd_bad) begin
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_BAD_CMD;
                        end else if (cmd_stop) begin
                            tx_valid <= 1'b1;
                            tx_data  <= (cmd_q == CMD_STOP_TEMP) ? RSP_STOP_TEMP : RSP_STOP_HUM;
                        end
                    end
                end
                S_DISPATCH: begin
                    sensor_start   <= ONE << addr_q;
                    sensor_command <= meas_type(cmd_q);
                end
                S_WAIT_SENSOR: begin
                    if (sel_done || to_expired) begin
                        tx_valid <= 1'b1;
                        if (sel_done && !sel_err) begin
                            tx_data <= rsp_code(cmd_q);
                            data_q  <= (cmd_q == CMD_STATUS) ? 8'h00 : sel_data;
                        end else begin
                            tx_data <= RSP_ERROR;
                            data_q  <= 8'h00;
                        end
                    end
                end
                S_SEND_CODE: begin
                    if (tx_ready) tx_data <= data_q;
                end
                S_SEND_DATA: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_hub.sv
// tb_sensor_hub: randomized requests against a table-level reply model.
// Sensors are emulated with programmable latency, data, error and silence.
module tb_sensor_hub;

    localparam int NS = 4;
    localparam int TO = 100;
    localparam int PP = 500;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            rx_valid = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic [NS-1:0]   sensor_start;
    logic [7:0]      sensor_command;
    logic [NS-1:0]   sensor_done = '0;
    logic [NS-1:0]   sensor_error = '0;
    logic [8*NS-1:0] sensor_data = '0;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b0;
    logic            busy;

    sensor_hub #(
        .NUM_SENSORS(NS),
        .TIMEOUT_CYCLES(TO),
        .POLL_PERIOD_CYCLES(PP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .sensor_start(sensor_start),
        .sensor_command(sensor_command),
        .sensor_done(sensor_done),
        .sensor_error(sensor_error),
        .sensor_data(sensor_data),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // sensor emulation controls
    bit         s_silent = 1'b0;
    bit         s_err = 1'b0;
    logic [7:0] s_data = 8'h00;
    int         s_delay = 1;
    bit         noise_en = 1'b0;
    bit         noise_ok = 1'b0;
    bit         armed = 1'b0;
    int         done_at = 0;
    int         cur_ch = 0;
    int         nz = 0;
    int         rdy_mode = 1;

    // monitor state
    logic [7:0]    txq[$];
    int            first_tx_cyc = -1;
    int            start_cyc = -1;
    int            start_hits = 0;
    logic [NS-1:0] start_vec = '0;
    logic [7:0]    start_cmd = 8'h00;
    bit            tx_v_prev = 1'b0;
    bit            hold_chk = 1'b0;
    logic [7:0]    held = 8'h00;

    // Observe outputs mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (hold_chk)
                chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
            if (tx_valid && !tx_v_prev) first_tx_cyc = cyc;
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            if (sensor_start != '0) begin
                start_hits++;
                start_cyc = cyc;
                start_vec = sensor_start;
                start_cmd = sensor_command;
                for (int i = 0; i < NS; i++) if (sensor_start[i]) cur_ch = i;
                armed    = !s_silent;
                done_at  = cyc + s_delay;
                noise_ok = 1'b1;
            end
        end
        hold_chk  = !reset && tx_valid && !tx_ready;
        held      = tx_data;
        tx_v_prev = tx_valid;
    end

    // Drive sensor strobes, stray completions and transmitter ready.
    always @(posedge clock) begin
        #1;
        sensor_done  = '0;
        sensor_error = '0;
        if (armed && cyc == done_at) begin
            sensor_done[cur_ch]          = 1'b1;
            sensor_error[cur_ch]         = s_err;
            sensor_data[8*cur_ch +: 8]   = s_data;
            armed = 1'b0;
        end else if (noise_en && noise_ok && busy && $urandom_range(0, 7) == 0) begin
            nz = $urandom_range(0, NS - 1);
            if (nz != cur_ch) begin
                sensor_done[nz]        = 1'b1;
                sensor_error[nz]       = 1'($urandom_range(0, 1));
                sensor_data[8*nz +: 8] = 8'($urandom);
            end
        end
        tx_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end

    function automatic logic [31:0] qat(input int i);
        return (txq.size() > i) ? {24'd0, txq[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One host request, checked against the reply table.
    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr,
                           input bit silent, input bit err,
                           input logic [7:0] dat, input int dly, input bit stray);
        logic [7:0] ec;
        logic [7:0] ed;
        logic [7:0] ecmd;
        bit         es;
        int         t;
        int         n0;
        int         budget;
        es = 1'b0; ed = 8'h00; ecmd = 8'h00; ec = 8'h00;
        if (addr >= NS) ec = 8'hFF;
        else if (cmd > 8'h06) ec = 8'hFE;
        else if (cmd == 8'h05) ec = 8'h0A;
        else if (cmd == 8'h06) ec = 8'h0B;
        else begin
            es = 1'b1;
            ecmd = (cmd == 8'h00) ? 8'h00 : (cmd == 8'h01 || cmd == 8'h03) ? 8'h01 : 8'h02;
            if (silent || err) ec = 8'h1F;
            else begin
                case (cmd)
                    8'h00: ec = 8'h07;
                    8'h01: begin ec = 8'h09; ed = dat; end
                    8'h02: begin ec = 8'h08; ed = dat; end
                    8'h03: begin ec = 8'h0D; ed = dat; end
                    default: begin ec = 8'h0E; ed = dat; end
                endcase
            end
        end
        s_silent = silent; s_err = err; s_data = dat; s_delay = dly;
        txq.delete();
        first_tx_cyc = -1;
        n0 = start_hits;
        noise_ok = 1'b0;
        send_byte(cmd);
        t = cyc;
        send_byte(addr);
        if (stray && es) begin
            tick(1);
            send_byte(8'($urandom));
        end
        budget = 0;
        while ((txq.size() < 2 || busy) && budget < 400) begin
            tick(1);
            budget++;
        end
        chk("txn_complete", 32'(budget < 400), 32'd1);
        chk("rsp_code", qat(0), {24'd0, ec});
        chk("rsp_data", qat(1), {24'd0, ed});
        chk("rsp_len", 32'(txq.size()), 32'd2);
        chk("start_count", 32'(start_hits - n0), 32'(es));
        if (es) begin
            chk("start_vec", 32'(start_vec), 32'(1 << addr));
            chk("start_cmd", 32'(start_cmd), 32'(ecmd));
            chk("start_cyc", 32'(start_cyc), 32'(t + 2));
            chk("code_lat", 32'(first_tx_cyc), 32'(t + 3 + (silent ? TO : dly)));
        end else if (ec == 8'hFF || ec == 8'hFE) begin
            chk("reject_lat", 32'(first_tx_cyc), 32'(t + 1));
        end
        tick($urandom_range(0, 4));
    endtask

    // Wait for one unsolicited continuous-mode reply.
    task automatic wait_poll(input logic [7:0] code, input int ch);
        int         prev;
        int         n0;
        int         budget;
        logic [7:0] d;
        prev = start_cyc;
        n0 = start_hits;
        d = 8'($urandom);
        s_data = d; s_err = 1'b0; s_silent = 1'b0; s_delay = $urandom_range(1, 10);
        txq.delete();
        noise_ok = 1'b0;
        budget = 0;
        while ((txq.size() < 2 || busy) && budget < 800) begin
            tick(1);
            budget++;
        end
        chk("poll_seen", 32'(budget < 800), 32'd1);
        chk("poll_code", qat(0), {24'd0, code});
        chk("poll_data", qat(1), {24'd0, d});
        chk("poll_vec", 32'(start_vec), 32'(1 << ch));
        chk("poll_hits", 32'(start_hits - n0), 32'd1);
        chk("poll_gap", 32'((start_cyc - prev) >= PP && (start_cyc - prev) <= PP + 20), 32'd1);
    endtask

    // Expect a window with no sensor activity and no reply bytes.
    task automatic quiet(input string tag, input int n);
        int n0;
        n0 = start_hits;
        txq.delete();
        tick(n);
        chk({tag, "_starts"}, 32'(start_hits - n0), 32'd0);
        chk({tag, "_tx"}, 32'(txq.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int budget;
        logic [7:0] c;
        logic [7:0] a;
        int r;

        tick(3);
        chk("rst_start", 32'(sensor_start), 32'd0);
        chk("rst_cmd", 32'(sensor_command), 32'd0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);

        rdy_mode = 1;
        run_txn(8'h01, 8'h02, 1'b0, 1'b0, 8'h19, 5, 1'b0);
        run_txn(8'h02, 8'h07, 1'b0, 1'b0, 8'h00, 1, 1'b0);

        txq.delete();
        send_byte(8'h01);
        t0 = cyc - 1;
        while (cyc < t0 + 101) tick(1);
        chk("addr_to_busy", 32'(busy), 32'd1);
        tick(1);
        chk("addr_to_idle", 32'(busy), 32'd0);
        chk("addr_to_tx", 32'(txq.size()), 32'd0);
        run_txn(8'h00, 8'h01, 1'b0, 1'b0, 8'h55, 3, 1'b0);

        run_txn(8'h01, 8'h03, 1'b1, 1'b0, 8'h00, 5, 1'b0);

        rdy_mode = 2;
        noise_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 11);
            if (r < 3) c = 8'h00;
            else if (r < 6) c = 8'h01;
            else if (r < 9) c = 8'h02;
            else if (r == 9) c = 8'($urandom_range(5, 6));
            else if (r == 10) c = 8'h07;
            else c = 8'($urandom_range(8, 255));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(4, 255));
            else a = 8'($urandom_range(0, 3));
            run_txn(c, a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    8'($urandom), $urandom_range(1, 25), ($urandom_range(0, 3) == 0));
        end

        run_txn(8'h03, 8'h01, 1'b0, 1'b0, 8'h1A, 4, 1'b0);
        wait_poll(8'h0D, 1);
        wait_poll(8'h0D, 1);
        run_txn(8'h05, 8'h01, 1'b0, 1'b0, 8'h00, 1, 1'b0);
        quiet("after_stop", 1200);

        run_txn(8'h04, 8'h02, 1'b0, 1'b0, 8'h3C, 6, 1'b0);
        rdy_mode = 0;
        s_silent = 1'b0; s_err = 1'b0; s_delay = 3;
        send_byte(8'h00);
        send_byte(8'h00);
        budget = 0;
        while (!tx_valid && budget < 50) begin
            tick(1);
            budget++;
        end
        chk("pre_rst_txv", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_txv", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_txd", 32'(tx_data), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rdy_mode = 2;
        quiet("after_reset", 1300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
